apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum consecutive wait cycles in ACCESS (legal range 2..255).
REQ-004 Ports:
- p_clk, in, 1: sole clock; all logic on the rising edge.
- p_reset_n, in, 1: reset, asynchronous and active-low.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: target address.
- cmd_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, DATA_W: read data; 0 for writes and timeouts.
- rsp_error, out, 1: p_slverr or timeout.
- p_sel, out, 1: APB select.
- p_enable, out, 1: APB enable.
- p_write, out, 1: APB direction.
- p_addr, out, ADDR_W: APB address.
- p_wdata, out, DATA_W: APB write data.
- p_rdata, in, DATA_W: completer read data.
- p_ready, in, 1: completer ready.
- p_slverr, in, 1: completer error, sampled only with p_ready.

Function
REQ-005 The FSM SHALL have states IDLE, SETUP and ACCESS.
- p_sel = (SETUP or ACCESS).
- p_enable = ACCESS.
REQ-006 cmd_ready SHALL be asserted in IDLE, and in ACCESS when p_ready is 1; it SHALL be low in all other cycles.
REQ-007 On an accepted command, the block SHALL register cmd_write, cmd_addr and cmd_wdata into p_write, p_addr and p_wdata, and go to SETUP on the next edge.
REQ-008 SETUP SHALL last exactly one cycle, then go unconditionally to ACCESS.
REQ-009 p_addr, p_write and p_wdata SHALL hold stable from SETUP through the final ACCESS cycle.
REQ-010 In ACCESS with p_ready=1, the transfer SHALL complete at that edge:
- rsp_valid=1 for exactly the next cycle.
- rsp_error = p_slverr.
- rsp_rdata = p_rdata for reads, 0 for writes.
REQ-011 On completion, the next state SHALL be SETUP if a command is accepted in the same cycle (back-to-back, p_sel stays high, p_enable drops), else IDLE.
REQ-012 In ACCESS with p_ready=0, the block SHALL stay in ACCESS and increment the wait counter.
REQ-013 The wait counter SHALL clear on entry to SETUP.
REQ-014 If p_ready stays 0 for TIMEOUT consecutive ACCESS cycles, the block SHALL end the transfer at that edge:
- Go to IDLE.
- Next cycle: rsp_valid=1, rsp_error=1, rsp_rdata=0.
- No command is accepted on that edge.
REQ-015 Minimum latency SHALL be: accept edge to rsp_valid = 3 cycles (SETUP, ACCESS, response).
REQ-016 rsp_valid SHALL NOT be asserted outside the cycle defined in REQ-010 and REQ-014.
REQ-017 cmd_* inputs SHALL be ignored while cmd_ready is low.
REQ-018 p_wdata SHALL drive the registered value for reads too (don't-care to the completer, but deterministic).

Reset
REQ-019 When p_reset_n=0, the block SHALL asynchronously go to IDLE and zero every output except cmd_ready:
- p_sel, p_enable, p_write, p_addr, p_wdata = 0.
- rsp_valid, rsp_rdata, rsp_error = 0.
- Wait counter = 0.
REQ-020 cmd_ready SHALL be 0 while p_reset_n=0 and SHALL assert in the first cycle after deassertion.
REQ-021 Reset during SETUP or ACCESS SHALL abort the transfer with no response pulse.
REQ-022 After reset deassertion, the block SHALL start in IDLE.

Structure
REQ-023 A shared package apb_pkg SHALL hold:
- The state enum (IDLE, SETUP, ACCESS).
- Default ADDR_W and DATA_W.
- The encoding constants shared with the APB completer.
REQ-024 The wait counter with timeout compare SHALL be one sub-module, apb_wait_cnt.
- Inputs: clear, enable.
- Output: expired.
- Parameter: TIMEOUT.

Verification
REQ-025 Write, zero wait: cmd write addr=0x03 wdata=0xA5, p_ready=1.
- Expect p_sel with p_enable=0 for 1 cycle, then p_enable=1 for 1 cycle, p_addr=0x03, p_wdata=0xA5.
- Expect rsp_valid pulse with rsp_error=0, rsp_rdata=0.
REQ-026 Read, 2 wait states: cmd read addr=0x05, p_ready low for 2 ACCESS cycles, then high with p_rdata=0x3C.
- Expect ACCESS for 3 cycles, then rsp_rdata=0x3C, rsp_error=0.
REQ-027 Back-to-back: cmd_valid held high for two writes (0x01/0x11, 0x02/0x22).
- Expect p_sel continuous for 4 cycles, p_enable pattern 0,1,0,1.
- Expect two rsp_valid pulses.
REQ-028 Slave error: read with p_ready=1, p_slverr=1.
- Expect rsp_error=1 with rsp_valid.
- Expect p_slverr ignored when p_ready=0.
REQ-029 Timeout: TIMEOUT=4, p_ready held 0.
- Expect exactly 4 ACCESS cycles, then IDLE with rsp_valid=1, rsp_error=1, rsp_rdata=0.
- Expect cmd_ready high the following cycle.
REQ-030 Mid-transfer reset: assert p_reset_n=0 during ACCESS.
- Expect p_sel and p_enable to drop to 0 immediately (asynchronously, before the next edge).
- Expect no rsp_valid.
- Expect a new command to complete normally after release.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB requester and its completers:
//               transfer state encoding, default bus widths and the PWRITE /
//               PSLVERR encodings used on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Default bus widths used when an instance does not override them.
  localparam int C_DEF_ADDR_W = 8;
  localparam int C_DEF_DATA_W = 8;

  // Wire encodings shared with every APB completer on the bus.
  localparam logic C_PWRITE_WRITE = 1'b1;
  localparam logic C_PSLVERR_ERR  = 1'b1;

  // Transfer phase of the requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_cnt
// Description : Counts consecutive ACCESS cycles in which the completer holds
//               p_ready low and flags the cycle in which the TIMEOUT-th such
//               cycle occurs.
// Ports       : p_clk     - clock, rising edge
//               p_reset_n - asynchronous active-low reset
//               clear     - restart the count (a new transfer is starting)
//               enable    - this cycle is an ACCESS cycle with p_ready low
//               expired   - this enabled cycle is the TIMEOUT-th in a row
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic p_clk,
  input  logic p_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count only ever needs to reach TIMEOUT-1: the TIMEOUT-th wait cycle
  // is recognised combinationally and ends the transfer at that edge.
  localparam int                 C_CNT_W = $clog2(TIMEOUT);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  logic [C_CNT_W-1:0] r_cnt;

  assign expired = enable && (r_cnt == C_LAST);

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_cnt <= '0;
    end else if (clear || expired) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

endmodule : apb_wait_cnt
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB requester. Accepts a command on a
//               valid/ready handshake, runs the SETUP and ACCESS phases, and
//               returns a one-cycle response pulse. A transfer whose
//               completer stalls for TIMEOUT ACCESS cycles is ended with an
//               error response.
// Ports       : p_clk, p_reset_n          - clock / async active-low reset
//               cmd_valid, cmd_ready       - command handshake
//               cmd_write, cmd_addr,
//               cmd_wdata                  - command payload
//               rsp_valid, rsp_rdata,
//               rsp_error                  - completion pulse and result
//               p_sel, p_enable, p_write,
//               p_addr, p_wdata            - APB request signals
//               p_rdata, p_ready, p_slverr - APB completer signals
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = C_DEF_ADDR_W,
  parameter int DATA_W  = C_DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              p_clk,
  input  logic              p_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              p_sel,
  output logic              p_enable,
  output logic              p_write,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_ready,
  input  logic              p_slverr
);

  apb_state_e        r_state;
  logic              r_p_sel;
  logic              r_p_enable;
  logic              r_p_write;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_p_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;

  logic w_accept;
  logic w_wait;
  logic w_expired;

  // Ready is combinational on p_ready so a completing transfer can hand
  // straight over to the next command. Gating with the reset input keeps it
  // low while reset is held even though the state already reads IDLE.
  assign cmd_ready = p_reset_n &&
                     ((r_state == IDLE) || ((r_state == ACCESS) && p_ready));
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_wait    = (r_state == ACCESS) && !p_ready;

  apb_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .p_clk     (p_clk),
    .p_reset_n (p_reset_n),
    .clear     (w_accept),
    .enable    (w_wait),
    .expired   (w_expired)
  );

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_state     <= IDLE;
      r_p_sel     <= 1'b0;
      r_p_enable  <= 1'b0;
      r_p_write   <= 1'b0;
      r_p_addr    <= '0;
      r_p_wdata   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      // Response fields are a single-cycle pulse unless a transfer ends here.
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= SETUP;
            r_p_sel    <= 1'b1;
            r_p_enable <= 1'b0;
            r_p_write  <= cmd_write;
            r_p_addr   <= cmd_addr;
            r_p_wdata  <= cmd_wdata;
          end
        end

        SETUP: begin
          r_state    <= ACCESS;
          r_p_enable <= 1'b1;
        end

        ACCESS: begin
          if (p_ready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= (p_slverr == C_PSLVERR_ERR);
            r_rsp_rdata <= (r_p_write == C_PWRITE_WRITE) ? '0 : p_rdata;
            r_p_enable  <= 1'b0;
            if (w_accept) begin
              // Back-to-back: p_sel stays high straight into the next SETUP.
              r_state   <= SETUP;
              r_p_write <= cmd_write;
              r_p_addr  <= cmd_addr;
              r_p_wdata <= cmd_wdata;
            end else begin
              r_state <= IDLE;
              r_p_sel <= 1'b0;
            end
          end else if (w_expired) begin
            // Completer never answered: give up and report an error.
            r_state     <= IDLE;
            r_p_sel     <= 1'b0;
            r_p_enable  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= C_PSLVERR_ERR;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_p_sel    <= 1'b0;
          r_p_enable <= 1'b0;
        end
      endcase
    end
  end

  assign p_sel     = r_p_sel;
  assign p_enable  = r_p_enable;
  assign p_write   = r_p_write;
  assign p_addr    = r_p_addr;
  assign p_wdata   = r_p_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Self-checking bench for apb_master (TIMEOUT = 4). A
//               transaction-level model predicts the bus and response
//               outputs every cycle; directed transfers check latency,
//               ACCESS-cycle counts and response contents against literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int TB_TIMEOUT = 4;

  logic       p_clk;
  logic       p_reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       p_sel;
  logic       p_enable;
  logic       p_write;
  logic [7:0] p_addr;
  logic [7:0] p_wdata;
  logic [7:0] p_rdata;
  logic       p_ready;
  logic       p_slverr;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_count = 0;

  apb_master #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .p_clk     (p_clk),
    .p_reset_n (p_reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .p_sel     (p_sel),
    .p_enable  (p_enable),
    .p_write   (p_write),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_rdata   (p_rdata),
    .p_ready   (p_ready),
    .p_slverr  (p_slverr)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  // A transfer is described by how many edges have passed since it was
  // accepted (1 = address phase, 2+ = data phase) and how many data-phase
  // cycles the completer has stalled.
  bit         m_busy;
  int         m_age;
  int         m_waits;
  logic       m_wr;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  bit         m_rv;
  logic       m_re;
  logic [7:0] m_rd;
  bit         m_acc;

  function automatic bit m_ready_now();
    return p_reset_n && (!m_busy || (m_age >= 2 && p_ready));
  endfunction

  always @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      m_busy = 0; m_age = 0; m_waits = 0;
      m_rv = 0; m_re = 0; m_rd = 8'h00;
    end else begin
      m_acc = cmd_valid && m_ready_now();
      m_rv  = 0;
      if (m_busy && m_age >= 2) begin
        if (p_ready) begin
          m_rv = 1; m_re = p_slverr; m_rd = m_wr ? 8'h00 : p_rdata;
          m_busy = 0;
        end else begin
          m_waits = m_waits + 1;
          if (m_waits == TB_TIMEOUT) begin
            m_rv = 1; m_re = 1; m_rd = 8'h00;
            m_busy = 0;
          end
        end
      end
      if (m_busy) m_age = m_age + 1;
      if (m_acc) begin
        m_busy = 1; m_age = 1; m_waits = 0;
        m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge p_clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready_now()));
    chk("p_sel", 32'(p_sel), 32'(m_busy));
    chk("p_enable", 32'(p_enable), 32'(m_busy && m_age >= 2));
    if (m_busy) begin
      chk("p_write", 32'(p_write), 32'(m_wr));
      chk("p_addr", 32'(p_addr), 32'(m_addr));
      chk("p_wdata", 32'(p_wdata), 32'(m_wdata));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rsp_error", 32'(rsp_error), 32'(m_re));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
    end
    if (rsp_valid) rv_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge p_clk);
  endtask

  // Issue one command and act as the completer: stall nwait ACCESS cycles
  // (with p_slverr high, which must be ignored), then answer with rd/err.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input int nwait, input logic [7:0] rd, input bit err,
                      output int n_acc, output int lat, output bit r_err,
                      output logic [7:0] r_data, output logic [7:0] acc_addr,
                      output logic [7:0] acc_wdata);
    int waits;
    bit got;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    p_ready = 0; p_slverr = 1; p_rdata = 8'hEE;
    mid();
    chk("xfer_idle_ready", 32'(cmd_ready), 32'd1);
    step();
    // Junk on the command bus must not disturb the transfer.
    cmd_valid = 0; cmd_write = ~wr; cmd_addr = 8'hFF; cmd_wdata = 8'h99;
    n_acc = 0; lat = 0; waits = 0; got = 0; r_err = 0; r_data = 8'h00;
    acc_addr = 8'h00; acc_wdata = 8'h00;
    for (int k = 0; k < 40 && !got; k++) begin
      if (p_enable) begin
        n_acc++;
        if (n_acc == 1) begin acc_addr = p_addr; acc_wdata = p_wdata; end
        if (waits < nwait) begin
          p_ready = 0; p_slverr = 1; waits++;
        end else begin
          p_ready = 1; p_slverr = err; p_rdata = rd;
        end
      end else begin
        p_ready = 1; p_slverr = 1; p_rdata = 8'hEE;
      end
      mid();
      if (rsp_valid) begin
        got = 1; lat = k + 1; r_err = rsp_error; r_data = rsp_rdata;
      end
      step();
    end
    p_ready = 0; p_slverr = 0;
    chk("xfer_rsp_seen", 32'(got), 32'd1);
    mid();
    chk("xfer_rsp_single", 32'(rsp_valid), 32'd0);
    chk("xfer_post_ready", 32'(cmd_ready), 32'd1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_p_sel"}, 32'(p_sel), 32'd0);
    chk({tag, "_p_enable"}, 32'(p_enable), 32'd0);
    chk({tag, "_p_write"}, 32'(p_write), 32'd0);
    chk({tag, "_p_addr"}, 32'(p_addr), 32'd0);
    chk({tag, "_p_wdata"}, 32'(p_wdata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         n_acc, lat, rv_before;
    bit         r_err;
    logic [7:0] r_data, acc_addr, acc_wdata, a0, a2, d2;
    logic [4:0] sel_v, en_v, rv_v;

    p_reset_n = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    p_rdata = 0; p_ready = 0; p_slverr = 0;
    #1 p_reset_n = 0;
    #1 check_reset_outputs("rst0");
    mid(); mid();
    #2 p_reset_n = 1;
    step();
    mid();
    chk("rst0_ready_after", 32'(cmd_ready), 32'd1);
    step();

    // Zero-wait write 0x03 <- 0xA5.
    xfer(1'b1, 8'h03, 8'hA5, 0, 8'h77, 1'b0, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_access", 32'(n_acc), 32'd1);
    chk("wr_addr", 32'(acc_addr), 32'h03);
    chk("wr_wdata", 32'(acc_wdata), 32'hA5);
    chk("wr_err", 32'(r_err), 32'd0);
    chk("wr_rdata", 32'(r_data), 32'h00);

    // Read 0x05 with two wait states, answer 0x3C.
    xfer(1'b0, 8'h05, 8'h5A, 2, 8'h3C, 1'b0, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("rd2w_lat", 32'(lat), 32'd5);
    chk("rd2w_access", 32'(n_acc), 32'd3);
    chk("rd2w_addr", 32'(acc_addr), 32'h05);
    chk("rd2w_wdata", 32'(acc_wdata), 32'h5A);
    chk("rd2w_err", 32'(r_err), 32'd0);
    chk("rd2w_rdata", 32'(r_data), 32'h3C);

    // Slave error on a read after one wait (p_slverr high while stalled).
    xfer(1'b0, 8'h09, 8'h00, 1, 8'hC3, 1'b1, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("slverr_lat", 32'(lat), 32'd4);
    chk("slverr_access", 32'(n_acc), 32'd2);
    chk("slverr_err", 32'(r_err), 32'd1);
    chk("slverr_rdata", 32'(r_data), 32'hC3);

    // One wait short of the limit: must still complete normally.
    xfer(1'b0, 8'h0B, 8'h00, TB_TIMEOUT - 1, 8'h81, 1'b0, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("edge_lat", 32'(lat), 32'd6);
    chk("edge_access", 32'(n_acc), 32'd4);
    chk("edge_err", 32'(r_err), 32'd0);
    chk("edge_rdata", 32'(r_data), 32'h81);

    // Completer never ready: timeout after exactly 4 ACCESS cycles.
    xfer(1'b0, 8'h0A, 8'h00, 100, 8'h55, 1'b0, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("tmo_lat", 32'(lat), 32'd6);
    chk("tmo_access", 32'(n_acc), 32'd4);
    chk("tmo_err", 32'(r_err), 32'd1);
    chk("tmo_rdata", 32'(r_data), 32'h00);

    // Back-to-back writes with cmd_valid held high.
    p_ready = 1; p_slverr = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h01; cmd_wdata = 8'h11;
    step();
    cmd_addr = 8'h02; cmd_wdata = 8'h22;
    a0 = 0; a2 = 0; d2 = 0; sel_v = 0; en_v = 0; rv_v = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      sel_v[4-i] = p_sel; en_v[4-i] = p_enable; rv_v[4-i] = rsp_valid;
      if (i == 0) a0 = p_addr;
      if (i == 2) begin a2 = p_addr; d2 = p_wdata; end
      step();
      if (i == 1) cmd_valid = 0;
    end
    p_ready = 0;
    chk("b2b_sel", 32'(sel_v), 32'b11110);
    chk("b2b_en", 32'(en_v), 32'b01010);
    chk("b2b_rv", 32'(rv_v), 32'b00101);
    chk("b2b_addr0", 32'(a0), 32'h01);
    chk("b2b_addr1", 32'(a2), 32'h02);
    chk("b2b_wdata1", 32'(d2), 32'h22);

    // Reset in the middle of a stalled ACCESS phase.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h07; cmd_wdata = 8'h00; p_ready = 0;
    step();
    cmd_valid = 0;
    step();
    chk("mrst_in_access", 32'(p_enable), 32'd1);
    rv_before = rv_count;
    #2 p_reset_n = 0;
    #1 check_reset_outputs("mrst");
    mid(); mid();
    #2 p_reset_n = 1;
    step();
    mid();
    chk("mrst_ready_after", 32'(cmd_ready), 32'd1);
    step(); step();
    chk("mrst_no_rsp", 32'(rv_count - rv_before), 32'd0);

    xfer(1'b1, 8'h0C, 8'h5A, 0, 8'h00, 1'b0, n_acc, lat, r_err, r_data, acc_addr, acc_wdata);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_addr", 32'(acc_addr), 32'h0C);
    chk("post_rst_err", 32'(r_err), 32'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_apb_master
`default_nettype wire
